bus_arbiter_rr: RTL and testbench

//  Round-robin arbiter for the shared system bus. Four bus masters compete;

---
 rtl/bus_arbiter_rr_pkg.sv | 24 ++
 rtl/bus_arbiter_rr_pick.sv | 31 +++
 rtl/bus_arbiter_rr.sv | 126 ++++++++++++
 tb/tb_bus_arbiter_rr.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_rr_pkg.sv
// Shared bus arbiter definitions: master count, owner encoding, FSM states,
// active-low grant levels and an owner-to-one-hot helper.
package bus_arbiter_rr_pkg;

    localparam int BUS_MASTER_CH = 4;
    localparam int BUS_OWNER_W   = 2;

    typedef logic [BUS_OWNER_W-1:0] bus_owner_t;

    typedef enum logic {
        BUS_ARB_STATE_IDLE = 1'b0,
        BUS_ARB_STATE_BUSY = 1'b1
    } bus_arb_state_e;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    function automatic logic [BUS_MASTER_CH-1:0] owner_onehot(input bus_owner_t idx);
        logic [BUS_MASTER_CH-1:0] one;
        one = {{(BUS_MASTER_CH-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first active, non-excluded request
// scanning last+1, last+2, ... modulo the master count.
import bus_arbiter_rr_pkg::*;

module bus_arb_rr_pick (
    input  logic [BUS_MASTER_CH-1:0] req,
    input  bus_owner_t               last,
    input  logic [BUS_MASTER_CH-1:0] exclude,
    output bus_owner_t               winner,
    output logic                     valid
);

    logic [BUS_MASTER_CH-1:0] elig;
    bus_owner_t               idx;

    assign elig = req & ~exclude;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int unsigned i = 1; i <= BUS_MASTER_CH; i++) begin
            idx = last + BUS_OWNER_W'(i);
            if (!valid && elig[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Four-master round-robin bus arbiter with registered active-low grants.
// Optional ownership timeout is built when BUS_ARB_TIMEOUT_EN is defined.
import bus_arbiter_rr_pkg::*;

module bus_arbiter_rr #(
    parameter int NUM_M     = 4,
    parameter int TO_CYCLES = 256,
    parameter int TO_CNT_W  = 16
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       m0_req_,
    input  logic       m1_req_,
    input  logic       m2_req_,
    input  logic       m3_req_,
    output logic       m0_grnt_,
    output logic       m1_grnt_,
    output logic       m2_grnt_,
    output logic       m3_grnt_,
    output logic [1:0] owner,
    output logic       busy,
    output logic       to_err
);

    bus_arb_state_e           state;
    bus_owner_t               last;
    logic [NUM_M-1:0]         req;
    logic [NUM_M-1:0]         grnt_q;
    logic [NUM_M-1:0]         pick_exclude;
    bus_owner_t               pick_winner;
    logic                     pick_valid;
    logic                     owner_req;
    logic                     timeout_hit;
    logic                     handover;

    assign req       = ~{m3_req_, m2_req_, m1_req_, m0_req_};
    assign owner_req = req[owner];
    assign handover  = (state == BUS_ARB_STATE_BUSY) && (!owner_req || timeout_hit);

    // A revoked owner sits out exactly one decision; a voluntary release
    // already removes it from req, so the mask only matters on timeout.
    assign pick_exclude = timeout_hit ? owner_onehot(owner) : '0;

    bus_arb_rr_pick u_pick (
        .req     (req),
        .last    (last),
        .exclude (pick_exclude),
        .winner  (pick_winner),
        .valid   (pick_valid)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    logic [TO_CNT_W-1:0] to_cnt;

    assign timeout_hit = (state == BUS_ARB_STATE_BUSY) && owner_req
                       && (to_cnt == TO_CNT_W'(TO_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            to_cnt <= '0;
            to_err <= 1'b0;
        end else begin
            to_err <= timeout_hit;
            if (state == BUS_ARB_STATE_BUSY && !handover)
                to_cnt <= to_cnt + 1'b1;
            else
                to_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign to_err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state  <= BUS_ARB_STATE_IDLE;
            owner  <= '0;
            last   <= bus_owner_t'(NUM_M - 1);
            busy   <= 1'b0;
            grnt_q <= {NUM_M{DISABLE_}};
        end else begin
            case (state)
                BUS_ARB_STATE_IDLE: begin
                    if (pick_valid) begin
                        state  <= BUS_ARB_STATE_BUSY;
                        owner  <= pick_winner;
                        last   <= pick_winner;
                        busy   <= 1'b1;
                        grnt_q <= ~owner_onehot(pick_winner);
                    end
                end
                BUS_ARB_STATE_BUSY: begin
                    if (handover) begin
                        if (pick_valid) begin
                            owner  <= pick_winner;
                            last   <= pick_winner;
                            grnt_q <= ~owner_onehot(pick_winner);
                        end else begin
                            state  <= BUS_ARB_STATE_IDLE;
                            busy   <= 1'b0;
                            grnt_q <= {NUM_M{DISABLE_}};
                        end
                    end
                end
                default: begin
                    state  <= BUS_ARB_STATE_IDLE;
                    busy   <= 1'b0;
                    grnt_q <= {NUM_M{DISABLE_}};
                end
            endcase
        end
    end

    assign m0_grnt_ = grnt_q[0];
    assign m1_grnt_ = grnt_q[1];
    assign m2_grnt_ = grnt_q[2];
    assign m3_grnt_ = grnt_q[3];

    a_cfg: assert property (@(posedge clk)
        (NUM_M == BUS_MASTER_CH) && (TO_CYCLES < (1 << TO_CNT_W)));

    a_grant_onehot: assert property (@(posedge clk) disable iff (!reset_)
        busy ? $onehot(~grnt_q) : (grnt_q == {NUM_M{DISABLE_}}));

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed self-checking bench for bus_arbiter_rr; the timeout scenario is
// selected by BUS_ARB_TIMEOUT_EN to match the build of the design.
module tb_bus_arbiter_rr;

    logic       clk = 1'b0;
    logic       reset_;
    logic       m0_req_, m1_req_, m2_req_, m3_req_;
    logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
    logic [1:0] owner;
    logic       busy;
    logic       to_err;

    int vectors    = 0;
    int miscompares = 0;

    bus_arbiter_rr #(
        .NUM_M     (4),
        .TO_CYCLES (8),
        .TO_CNT_W  (16)
    ) dut (
        .clk      (clk),
        .reset_   (reset_),
        .m0_req_  (m0_req_),
        .m1_req_  (m1_req_),
        .m2_req_  (m2_req_),
        .m3_req_  (m3_req_),
        .m0_grnt_ (m0_grnt_),
        .m1_grnt_ (m1_grnt_),
        .m2_grnt_ (m2_grnt_),
        .m3_grnt_ (m3_grnt_),
        .owner    (owner),
        .busy     (busy),
        .to_err   (to_err)
    );

    always #5 clk = ~clk;

    // Active-high views of the request/grant buses.
    function automatic logic [3:0] grants();
        return ~{m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};
    endfunction

    task automatic set_req(input logic [3:0] r);
        {m3_req_, m2_req_, m1_req_, m0_req_} = ~r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_ = 1'b0;
        set_req(4'hF);
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (grants() !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0 || to_err !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold: grants=%b busy=%b owner=%0d to_err=%b, want 0000/0/0/0",
                         grants(), busy, owner, to_err);
            end
        end
        reset_ = 1'b1;
        step();
        vectors++;
        if (grants() !== 4'b0001 || owner !== 2'd0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: grants=%b owner=%0d busy=%b, want 0001/0/1",
                     grants(), owner, busy);
        end
    endtask

    // Entry: m0 owns, all four requesting.
    task automatic test_fairness();
        logic [1:0] cur;
        logic [1:0] nxt;
        logic [3:0] exp;
        logic [3:0] rel;
        cur = 2'd0;
        step();
        vectors++;
        if (grants() !== 4'b0001) begin
            miscompares++;
            $display("FAIL fair_hold0: grants=%b, want 0001", grants());
        end
        for (int i = 0; i < 4; i++) begin
            nxt = cur + 2'd1;
            exp = 4'b0001 << nxt;
            rel = 4'hF & ~(4'b0001 << cur);
            set_req(rel);
            step();
            vectors++;
            if (grants() !== exp || owner !== nxt || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL fair_handover%0d: grants=%b owner=%0d busy=%b, want %b/%0d/1",
                         i, grants(), owner, busy, exp, nxt);
            end
            set_req(4'hF);
            step();
            vectors++;
            if (grants() !== exp) begin
                miscompares++;
                $display("FAIL fair_hold%0d: grants=%b, want %b", i, grants(), exp);
            end
            cur = nxt;
        end
    endtask

    // Entry: m0 owns, all requesting.
    task automatic test_hold();
        set_req(4'b0100);
        step();
        vectors++;
        if (grants() !== 4'b0100 || owner !== 2'd2) begin
            miscompares++;
            $display("FAIL hold_take: grants=%b owner=%0d, want 0100/2", grants(), owner);
        end
        set_req(4'b0111);
        for (int i = 0; i < 50; i++) begin
            step();
            vectors++;
            if (grants() !== 4'b0100) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: grants=%b, want 0100", i, grants());
            end
        end
        set_req(4'b0011);
        step();
        vectors++;
        if (grants() !== 4'b0001 || owner !== 2'd0) begin
            miscompares++;
            $display("FAIL hold_release: grants=%b owner=%0d, want 0001/0", grants(), owner);
        end
    endtask

    // Entry: m0 owns, m1 requesting.
    task automatic test_release_idle();
        set_req(4'b0010);
        step();
        vectors++;
        if (grants() !== 4'b0010 || owner !== 2'd1) begin
            miscompares++;
            $display("FAIL idle_take: grants=%b owner=%0d, want 0010/1", grants(), owner);
        end
        set_req(4'b0000);
        step();
        vectors++;
        if (grants() !== 4'b0000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_drop: grants=%b busy=%b, want 0000/0", grants(), busy);
        end
        set_req(4'b1000);
        step();
        vectors++;
        if (grants() !== 4'b1000 || owner !== 2'd3 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_regrant: grants=%b owner=%0d busy=%b, want 1000/3/1",
                     grants(), owner, busy);
        end
    endtask

`ifdef BUS_ARB_TIMEOUT_EN
    // Entry: m3 owns. TO_CYCLES = 8.
    task automatic test_timeout();
        set_req(4'b0001);
        step();
        vectors++;
        if (grants() !== 4'b0001) begin
            miscompares++;
            $display("FAIL to_take: grants=%b, want 0001", grants());
        end
        set_req(4'b0101);
        for (int i = 0; i < 7; i++) begin
            step();
            vectors++;
            if (grants() !== 4'b0001 || to_err !== 1'b0) begin
                miscompares++;
                $display("FAIL to_hold%0d: grants=%b to_err=%b, want 0001/0", i, grants(), to_err);
            end
        end
        step();
        vectors++;
        if (grants() !== 4'b0100 || owner !== 2'd2 || to_err !== 1'b1) begin
            miscompares++;
            $display("FAIL to_revoke: grants=%b owner=%0d to_err=%b, want 0100/2/1",
                     grants(), owner, to_err);
        end
        step();
        vectors++;
        if (grants() !== 4'b0100 || to_err !== 1'b0) begin
            miscompares++;
            $display("FAIL to_pulse_end: grants=%b to_err=%b, want 0100/0", grants(), to_err);
        end
        set_req(4'b0001);
        step();
        vectors++;
        if (grants() !== 4'b0001) begin
            miscompares++;
            $display("FAIL to_solo_take: grants=%b, want 0001", grants());
        end
        for (int i = 0; i < 7; i++) begin
            step();
            vectors++;
            if (grants() !== 4'b0001 || to_err !== 1'b0) begin
                miscompares++;
                $display("FAIL to_solo_hold%0d: grants=%b to_err=%b, want 0001/0", i, grants(), to_err);
            end
        end
        step();
        vectors++;
        if (grants() !== 4'b0000 || busy !== 1'b0 || to_err !== 1'b1) begin
            miscompares++;
            $display("FAIL to_solo_idle: grants=%b busy=%b to_err=%b, want 0000/0/1",
                     grants(), busy, to_err);
        end
        step();
        vectors++;
        if (grants() !== 4'b0001 || busy !== 1'b1 || to_err !== 1'b0) begin
            miscompares++;
            $display("FAIL to_solo_regrant: grants=%b busy=%b to_err=%b, want 0001/1/0",
                     grants(), busy, to_err);
        end
    endtask
`else
    // Entry: m3 owns. Without the timeout the owner keeps the bus.
    task automatic test_timeout();
        set_req(4'b0001);
        step();
        vectors++;
        if (grants() !== 4'b0001) begin
            miscompares++;
            $display("FAIL noto_take: grants=%b, want 0001", grants());
        end
        set_req(4'b0101);
        for (int i = 0; i < 1000; i++) begin
            step();
            vectors++;
            if (grants() !== 4'b0001 || to_err !== 1'b0) begin
                miscompares++;
                $display("FAIL noto_hold%0d: grants=%b to_err=%b, want 0001/0", i, grants(), to_err);
            end
        end
    endtask
`endif

    // Entry: m0 owns.
    task automatic test_async_reset();
        set_req(4'b1000);
        step();
        vectors++;
        if (grants() !== 4'b1000 || owner !== 2'd3) begin
            miscompares++;
            $display("FAIL arst_take: grants=%b owner=%0d, want 1000/3", grants(), owner);
        end
        #2;
        reset_ = 1'b0;
        #1;
        vectors++;
        if (grants() !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0) begin
            miscompares++;
            $display("FAIL arst_drop: grants=%b busy=%b owner=%0d, want 0000/0/0",
                     grants(), busy, owner);
        end
        set_req(4'b0000);
        step();
        reset_ = 1'b1;
        step();
        vectors++;
        if (grants() !== 4'b0000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL arst_idle: grants=%b busy=%b, want 0000/0", grants(), busy);
        end
    endtask

    initial begin
        reset_ = 1'b0;
        set_req(4'b0000);
        test_reset();
        test_fairness();
        test_hold();
        test_release_idle();
        test_timeout();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
